// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT + 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned magnitude datapath: radix-2 shift-add multiply or restoring
// divide, one step per enable. acc holds {HI,LO} of the product, or
// {remainder, quotient} for a divide, once ITER_COUNT steps have run.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   opnd;
  logic               div_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH+1:0]   div_diff;

  // One iteration: add-then-shift-right for multiply, shift-then-trial-subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_trial} - {2'b00, opnd};
    acc_next  = acc;
    if (div_q) begin
      if (!div_diff[WIDTH+1])
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Operand capture on load, then step the accumulator and counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, a};
      opnd  <= b;
      div_q <= is_div;
      count <= '0;
    end else if (en) begin
      acc   <= acc_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling, HI/LO registers and
// MTHI/MTLO. Define MDU_FAST_MULT_EN for a single-cycle MULT/MULTU.
//
//   state   | meaning
//   IDLE    | waiting for start; MTHI/MTLO accepted
//   RUN     | iterating; the final cycle (count at terminal) writes HI/LO
//   DONE    | done pulse; start or MTHI/MTLO accepted
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state, state_nxt;
  logic               accept, in_div, in_sgn, div_zero, last, core_load, core_en;
  logic               div_q, neg_res, neg_rem;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [CNT_W-1:0]   core_count;
  logic [2*WIDTH-1:0] core_acc;
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;
`endif

  assign in_div   = op_is_div(op);
  assign in_sgn   = op_is_signed(op);
  assign div_zero = in_div && (rt_val == '0);
  assign accept   = start && (state != ST_RUN);
  assign last     = (core_count == CNT_W'(ITER_COUNT));
  // The terminal RUN cycle only writes back, so it is not reported as busy.
  assign core_en  = (state == ST_RUN) && !last;
  assign busy     = core_en;
  assign done     = (state == ST_DONE);
  assign mag_a    = (in_sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign mag_b    = (in_sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;

`ifdef MDU_FAST_MULT_EN
  // Single-cycle product from sign- or zero-extended operands
  always_comb begin
    fast_a    = {{WIDTH{in_sgn & rs_val[WIDTH-1]}}, rs_val};
    fast_b    = {{WIDTH{in_sgn & rt_val[WIDTH-1]}}, rt_val};
    fast_prod = fast_a * fast_b;
  end
`endif

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .en     (core_en),
    .is_div (in_div),
    .a      (mag_a),
    .b      (mag_b),
    .count  (core_count),
    .acc    (core_acc)
  );

  // Sign fixup of the raw magnitude result
  always_comb begin
    res_hi = core_acc[2*WIDTH-1:WIDTH];
    res_lo = core_acc[WIDTH-1:0];
    if (div_q) begin
      if (neg_res) res_lo = -core_acc[WIDTH-1:0];
      if (neg_rem) res_hi = -core_acc[2*WIDTH-1:WIDTH];
    end else if (neg_res) begin
      {res_hi, res_lo} = -core_acc;
    end
  end

  // Next-state and core load decode
  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (div_zero) begin
            state_nxt = ST_DONE;
`ifdef MDU_FAST_MULT_EN
          end else if (!in_div) begin
            state_nxt = ST_DONE;
`endif
          end else begin
            state_nxt = ST_RUN;
            core_load = 1'b1;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN:  if (last) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // HI/LO and sign flags; a start always beats a same-cycle MTHI/MTLO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi      <= '0;
      lo      <= '0;
      div_q   <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      div_q   <= in_div;
      neg_res <= in_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_rem <= in_sgn & rs_val[WIDTH-1];
      if (div_zero) begin
        hi <= rs_val;
        lo <= '1;
`ifdef MDU_FAST_MULT_EN
      end else if (!in_div) begin
        {hi, lo} <= fast_prod;
`endif
      end
    end else if (state == ST_RUN) begin
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      if (mthi_we) hi <= wd;
      if (mtlo_we) lo <= wd;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + scoreboard bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0, wd = '0;
  logic        mthi_we = 1'b0, mtlo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edge_n;
    int          busy_n;
    string       tag;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .wd      (wd),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural MIPS reference: returns {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        q, r;
    longint             sp;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin sp = longint'(sa) * longint'(sb); return sp; end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; pushes expectation, drives one start edge, returns at next negedge
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t        e;
    logic [63:0] m;
    m = model(o, a, b);
    e.hi = m[63:32];
    e.lo = m[31:0];
    e.tag = tag;
    if (o[1] && b == 0) begin
      e.edge_n = 0; e.busy_n = 0;
    end else begin
`ifdef MDU_FAST_MULT_EN
      if (!o[1]) begin e.edge_n = 0; e.busy_n = 0; end
      else begin e.edge_n = 33; e.busy_n = 32; end
`else
      e.edge_n = 33; e.busy_n = 32;
`endif
    end
    sb.push_back(e);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Waits for done (bounded), pops and compares. intf_at >= 0 injects start+MTHI at that cycle.
  task automatic wait_done(input int intf_at);
    int   edge_idx, busy_n;
    exp_t e;
    edge_idx = 0;
    busy_n = 0;
    while (!done && edge_idx < 100) begin
      if (busy) busy_n++;
      if (edge_idx == intf_at) begin
        start = 1'b1; mthi_we = 1'b1; wd = 32'hAAAA_5555;
        op = 2'b11; rs_val = 32'd99; rt_val = 32'd5;
      end
      @(posedge clk);
      #1 begin start = 1'b0; mthi_we = 1'b0; end
      edge_idx++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({e.tag, " done_seen"}, {31'b0, done}, 32'd1);
    chk({e.tag, " latency"}, edge_idx, e.edge_n);
    chk({e.tag, " busy_cycles"}, busy_n, e.busy_n);
    chk({e.tag, " hi"}, hi, e.hi);
    chk({e.tag, " lo"}, lo, e.lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #2;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    launch(2'b00, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    wait_done(-1);
    @(negedge clk);
    chk("done_one_pulse", {31'b0, done}, 32'd0);

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    wait_done(-1);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    wait_done(-1);
    launch(2'b11, 32'd7, 32'd2, "divu_7_2");
    wait_done(-1);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    wait_done(-1);
    launch(2'b11, 32'h1234_5678, 32'd0, "divu_zero");
    wait_done(-1);
    launch(2'b10, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
    wait_done(-1);

    // start + MTHI mid-operation are both ignored
    launch(2'b00, 32'd12345, 32'hFFFF_FF00, "mult_intf");
    wait_done(4);
    @(negedge clk);

    // MTHI / MTLO in IDLE
    mthi_we = 1'b1; wd = 32'hAAAA_5555;
    @(posedge clk); #1 mthi_we = 1'b0;
    @(negedge clk);
    chk("mthi_idle", hi, 32'hAAAA_5555);
    mtlo_we = 1'b1; wd = 32'h1357_9BDF;
    @(posedge clk); #1 mtlo_we = 1'b0;
    @(negedge clk);
    chk("mtlo_idle", lo, 32'h1357_9BDF);

    // start wins over a same-cycle MTHI
    mthi_we = 1'b1; wd = 32'hDEAD_BEEF;
    launch(2'b11, 32'd100, 32'd7, "divu_start_wins");
    mthi_we = 1'b0;
    chk("mthi_dropped_on_start", hi, 32'hAAAA_5555);
    wait_done(-1);

    // back-to-back start during DONE
    launch(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b2b_first");
    wait_done(-1);
    launch(2'b10, 32'hFFFF_FF9C, 32'd7, "b2b_second");
    wait_done(-1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 5) ? 32'd1 : $urandom;
      launch(2'(i % 4), ra, rb, $sformatf("rand%0d", i));
      wait_done(-1);
    end

    // reset mid-operation
    launch(2'b10, 32'd1000, 32'd3, "div_reset");
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset hi", hi, 32'h0);
    chk("midreset lo", lo, 32'h0);
    void'(sb.pop_back());
    #3 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("postreset done", {31'b0, done}, 32'd0);
    chk("scoreboard empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
